seg_scan_controller: RTL

- Sequencing controller for the 4-digit multiplexed seven-segment display.
- Accepts a 14-bit binary value through a valid/ready handshake and converts it to four BCD digits with an iterative shift-add-3 (double-dabble) FSM.
- Commits the digits atomically to display registers, and owns digit scanning with inter-digit blanking, leading-zero blanking and over-range indication.
- Sits between the counting/measurement logic and the board's anode/cathode pins.

---
 rtl/seg_scan_controller.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/seg_scan_controller.sv
// Four-digit seven-segment scan controller.
// Binary-to-BCD via double dabble, atomic commit, blanked multiplexed scan.
module seg_scan_controller #(
  parameter int CLK_DIV      = 199999,
  parameter int BLANK_CYCLES = 2000
) (
  input  logic        clkin,
  input  logic        reset,
  input  logic [13:0] value,
  input  logic        value_valid,
  output logic        value_ready,
  input  logic        lz_blank,
  output logic [3:0]  seg_select,
  output logic [7:0]  seg_code,
  output logic        overrange
);

  localparam int PW = $clog2(CLK_DIV + 1);
  localparam logic [PW-1:0] P_TC  = CLK_DIV[PW-1:0];
  localparam logic [PW-1:0] P_BLK = BLANK_CYCLES[PW-1:0];

  typedef enum logic [1:0] {IDLE, CONV, COMMIT} state_t;

  state_t        state_q, state_d;
  logic [13:0]   sh_q, sh_d;
  logic [15:0]   bcd_q, bcd_d;
  logic [3:0]    it_q, it_d;
  logic          pend_q, pend_d;
  logic [15:0]   dig_q, dig_d;
  logic          ovr_q, ovr_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [1:0]    idx_q, idx_d;
  logic [3:0]    sel_q, sel_d;
  logic [7:0]    code_q, code_d;
  logic [15:0]   adj;
  logic [3:0]    nib;
  logic          lz_hit;

  function automatic logic [7:0] dec(input logic [3:0] d);
    logic [7:0] c;
    case (d)
      4'd0:    c = 8'b00000011;
      4'd1:    c = 8'b10011111;
      4'd2:    c = 8'b00100101;
      4'd3:    c = 8'b00001101;
      4'd4:    c = 8'b10011001;
      4'd5:    c = 8'b01001001;
      4'd6:    c = 8'b01000001;
      4'd7:    c = 8'b00011111;
      4'd8:    c = 8'b00000001;
      4'd9:    c = 8'b00001001;
      default: c = 8'b11111111;
    endcase
    return c;
  endfunction

  assign value_ready = (state_q == IDLE);

  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    bcd_d   = bcd_q;
    it_d    = it_q;
    pend_d  = pend_q;
    dig_d   = dig_q;
    ovr_d   = ovr_q;
    adj     = bcd_q;
    for (int n = 0; n < 4; n++) begin
      if (adj[n*4 +: 4] >= 4'd5) adj[n*4 +: 4] = adj[n*4 +: 4] + 4'd3;
    end
    unique case (state_q)
      IDLE: begin
        if (value_valid) begin
          sh_d    = value;
          bcd_d   = '0;
          it_d    = '0;
          pend_d  = (value > 14'd9999);
          state_d = CONV;
        end
      end
      CONV: begin
        {bcd_d, sh_d} = {adj[14:0], sh_q, 1'b0};
        it_d = it_q + 4'd1;
        if (it_q == 4'd13) state_d = COMMIT;
      end
      COMMIT: begin
        ovr_d = pend_q;
        if (!pend_q) dig_d = bcd_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    presc_d = (presc_q == P_TC) ? '0 : presc_q + 1'b1;
    idx_d   = (presc_q == P_TC) ? idx_q + 2'd1 : idx_q;
    unique case (idx_q)
      2'd0: begin nib = dig_q[3:0];   lz_hit = 1'b0;                 end
      2'd1: begin nib = dig_q[7:4];   lz_hit = (dig_q[15:4] == '0);  end
      2'd2: begin nib = dig_q[11:8];  lz_hit = (dig_q[15:8] == '0);  end
      default: begin nib = dig_q[15:12]; lz_hit = (dig_q[15:12] == '0); end
    endcase
    sel_d  = 4'b1111;
    code_d = 8'hFF;
    if (presc_q >= P_BLK) begin
      sel_d = ~(4'b0001 << idx_q);
      if (ovr_q)                 code_d = 8'b11111101;
      else if (lz_blank && lz_hit) code_d = 8'hFF;
      else                       code_d = dec(nib);
    end
  end

  always_ff @(posedge clkin or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      sh_q    <= '0;
      bcd_q   <= '0;
      it_q    <= '0;
      pend_q  <= 1'b0;
      dig_q   <= '0;
      ovr_q   <= 1'b0;
      presc_q <= '0;
      idx_q   <= '0;
      sel_q   <= 4'b1111;
      code_q  <= 8'hFF;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      bcd_q   <= bcd_d;
      it_q    <= it_d;
      pend_q  <= pend_d;
      dig_q   <= dig_d;
      ovr_q   <= ovr_d;
      presc_q <= presc_d;
      idx_q   <= idx_d;
      sel_q   <= sel_d;
      code_q  <= code_d;
    end
  end

  assign seg_select = sel_q;
  assign seg_code   = code_q;
  assign overrange  = ovr_q;

endmodule
